// File: rtl/frame_ring_buf.sv
// frame_ring_buf
//   Multi-bank AXI-Stream frame buffer. NUM_BANKS frames of up to MAX_FRAME_LEN
//   beats are held in one synchronous-read memory. Committed frames are queued
//   in FIFO order and handed to the reader when i_swap_ok is high.
//   DROP_OLDEST=0 stalls the producer when no bank is free. DROP_OLDEST=1
//   instead reclaims the oldest queued (unread) frame.
//
// Ports
//   i_clk, i_rstn                       clock, synchronous active-low reset
//   i_s_valid/o_s_ready/i_s_data/i_s_last  AXIS slave (frame input)
//   o_m_valid/i_m_ready/o_m_data/o_m_last  AXIS master (frame output)
//   i_swap_ok                           reader may start the next queued frame
//   o_queued                            committed frames waiting for the reader
//   o_trunc                             pulse: frame clipped at MAX_FRAME_LEN
//   o_drop                              pulse: queued frame overwritten
//
// Optional build macro FRAME_STATS_EN adds 16-bit wrapping counters
//   o_frames_in, o_frames_out and o_frames_dropped.
module frame_ring_buf #(
   parameter int DATA_WIDTH    = 12,
   parameter int MAX_FRAME_LEN = 1024,
   parameter int NUM_BANKS     = 3,
   parameter int DROP_OLDEST   = 0,
   parameter int LEN_W         = $clog2(MAX_FRAME_LEN+1)
) (
   input  logic                           i_clk,
   input  logic                           i_rstn,
   input  logic                           i_s_valid,
   output logic                           o_s_ready,
   input  logic [DATA_WIDTH-1:0]          i_s_data,
   input  logic                           i_s_last,
   output logic                           o_m_valid,
   input  logic                           i_m_ready,
   output logic [DATA_WIDTH-1:0]          o_m_data,
   output logic                           o_m_last,
   input  logic                           i_swap_ok,
   output logic [$clog2(NUM_BANKS+1)-1:0] o_queued,
   output logic                           o_trunc,
   output logic                           o_drop
`ifdef FRAME_STATS_EN
   ,
   output logic [15:0]                    o_frames_in,
   output logic [15:0]                    o_frames_out,
   output logic [15:0]                    o_frames_dropped
`endif
);
   localparam int BW    = $clog2(NUM_BANKS);
   localparam int QW    = $clog2(NUM_BANKS+1);
   localparam int DEPTH = NUM_BANKS * MAX_FRAME_LEN;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_FRAME_LEN);

   typedef enum logic [1:0] {B_FREE, B_FILL, B_QUEUED, B_READ} bank_st_e;
   typedef enum logic {R_IDLE, R_DRAIN} rd_st_e;

   bank_st_e                bank_st_q [NUM_BANKS], bank_st_d [NUM_BANKS];
   logic [LEN_W-1:0]        len_q     [NUM_BANKS], len_d     [NUM_BANKS];
   logic [BW-1:0]           qent_q    [NUM_BANKS], qent_d    [NUM_BANKS];
   logic [BW-1:0]           qhead_q, qhead_d;
   logic [QW-1:0]           qcnt_q, qcnt_d;
   logic                    wr_act_q, wr_act_d;
   logic [BW-1:0]           wr_bank_q, wr_bank_d;
   logic [LEN_W-1:0]        wcnt_q, wcnt_d;
   rd_st_e                  rd_st_q, rd_st_d;
   logic [BW-1:0]           rd_bank_q, rd_bank_d;
   logic [LEN_W-1:0]        rd_len_q, rd_len_d, rcnt_q, rcnt_d;
   logic                    rv_q, rv_d, rl_q, rl_d;
   logic [DATA_WIDTH-1:0]   fifo_dat_q [2], fifo_dat_d [2];
   logic                    fifo_last_q [2], fifo_last_d [2];
   logic                    fifo_rp_q, fifo_rp_d;
   logic [1:0]              fifo_occ_q, fifo_occ_d;
   logic                    rdy_en_q, trunc_q, trunc_d, drop_q, drop_d;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic                    free_any, s_ready, s_fire, m_fire, issue_ok;
   logic [BW-1:0]           free_idx, w_bank, head_bank, drop_slot;
   logic [LEN_W-1:0]        w_cnt;
   logic                    we, commit, pop_r, last_fire;
   logic [AW-1:0]           waddr, raddr;
   logic                    fifo_wp;

   // Circular index into the bank-index queue; off never exceeds NUM_BANKS.
   function automatic logic [BW-1:0] qidx(input logic [BW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_BANKS) s = s - NUM_BANKS;
      return BW'(s);
   endfunction

   function automatic logic [AW-1:0] mk_addr(input logic [BW-1:0] b, input logic [LEN_W-1:0] i);
      return AW'(b) * AW'(MAX_FRAME_LEN) + AW'(i);
   endfunction

   assign o_s_ready = s_ready;
   assign o_m_valid = (fifo_occ_q != 2'd0);
   assign o_m_data  = fifo_dat_q[fifo_rp_q];
   assign o_m_last  = fifo_last_q[fifo_rp_q];
   assign o_queued  = qcnt_q;
   assign o_trunc   = trunc_q;
   assign o_drop    = drop_q;

   always_comb begin
      bank_st_d   = bank_st_q;
      len_d       = len_q;
      qent_d      = qent_q;
      qhead_d     = qhead_q;
      qcnt_d      = qcnt_q;
      wr_act_d    = wr_act_q;
      wr_bank_d   = wr_bank_q;
      wcnt_d      = wcnt_q;
      rd_st_d     = rd_st_q;
      rd_bank_d   = rd_bank_q;
      rd_len_d    = rd_len_q;
      rcnt_d      = rcnt_q;
      fifo_dat_d  = fifo_dat_q;
      fifo_last_d = fifo_last_q;
      fifo_rp_d   = fifo_rp_q;
      fifo_occ_d  = fifo_occ_q;
      rv_d        = 1'b0;
      rl_d        = 1'b0;
      raddr       = '0;
      pop_r       = 1'b0;
      last_fire   = 1'b0;
      trunc_d     = 1'b0;
      drop_d      = 1'b0;
      commit      = 1'b0;
      we          = 1'b0;
      head_bank   = qent_q[qhead_q];

      // Lowest-index free bank; a bank freed this cycle only counts next cycle.
      free_any = 1'b0;
      free_idx = '0;
      for (int b = NUM_BANKS-1; b >= 0; b--) begin
         if (bank_st_q[b] == B_FREE) begin
            free_any = 1'b1;
            free_idx = BW'(b);
         end
      end

      // Credit: skid entries plus the read in flight may never exceed two.
      m_fire   = o_m_valid & i_m_ready;
      issue_ok = (int'(fifo_occ_q) + int'(rv_q) - int'(m_fire)) < 2;

      // Reader. The first beat is read in the pop cycle itself so that
      // o_m_valid rises two cycles after the pop.
      case (rd_st_q)
         R_IDLE: begin
            if (qcnt_q != '0 && i_swap_ok) begin
               pop_r              = 1'b1;
               rd_st_d            = R_DRAIN;
               rd_bank_d          = head_bank;
               rd_len_d           = len_q[head_bank];
               bank_st_d[head_bank] = B_READ;
               rv_d               = 1'b1;
               rl_d               = (len_q[head_bank] == LEN_W'(1));
               raddr              = mk_addr(head_bank, '0);
               rcnt_d             = LEN_W'(1);
            end
         end
         default: begin
            if (rcnt_q < rd_len_q && issue_ok) begin
               rv_d   = 1'b1;
               rl_d   = (rcnt_q == rd_len_q - LEN_W'(1));
               raddr  = mk_addr(rd_bank_q, rcnt_q);
               rcnt_d = rcnt_q + LEN_W'(1);
            end
            if (m_fire && o_m_last) begin
               last_fire            = 1'b1;
               bank_st_d[rd_bank_q] = B_FREE;
               rd_st_d              = R_IDLE;
            end
         end
      endcase

      // Writer. With no free bank in drop mode the oldest queued frame is
      // reclaimed; if the reader pops the head this same cycle, take the next.
      s_ready   = rdy_en_q & (wr_act_q | free_any | ((DROP_OLDEST != 0) && (qcnt_q != '0)));
      s_fire    = i_s_valid & s_ready;
      drop_slot = pop_r ? qidx(qhead_q, 1) : qhead_q;
      w_bank    = wr_bank_q;
      w_cnt     = wr_act_q ? wcnt_q : '0;
      if (s_fire) begin
         if (!wr_act_q) begin
            if (free_any) begin
               w_bank = free_idx;
            end else begin
               drop_d = 1'b1;
               w_bank = qent_q[drop_slot];
            end
         end
         we = (w_cnt < MAXL);
         if (i_s_last) begin
            commit            = 1'b1;
            trunc_d           = (w_cnt == MAXL);
            len_d[w_bank]     = (w_cnt == MAXL) ? MAXL : w_cnt + LEN_W'(1);
            bank_st_d[w_bank] = B_QUEUED;
            qent_d[qidx(qhead_q, int'(qcnt_q))] = w_bank;
            wr_act_d          = 1'b0;
            wcnt_d            = '0;
         end else begin
            bank_st_d[w_bank] = B_FILL;
            wr_act_d          = 1'b1;
            wr_bank_d         = w_bank;
            wcnt_d            = we ? w_cnt + LEN_W'(1) : w_cnt;
         end
      end
      waddr = mk_addr(w_bank, w_cnt);

      qhead_d = qidx(qhead_q, int'(pop_r) + int'(drop_d));
      qcnt_d  = QW'(int'(qcnt_q) + int'(commit) - int'(pop_r) - int'(drop_d));

      // Two-entry skid FIFO fed by the memory read register.
      fifo_wp = fifo_rp_q ^ fifo_occ_q[0];
      if (rv_q) begin
         fifo_dat_d[fifo_wp]  = rdata_q;
         fifo_last_d[fifo_wp] = rl_q;
      end
      if (m_fire) fifo_rp_d = ~fifo_rp_q;
      fifo_occ_d = fifo_occ_q + {1'b0, rv_q} - {1'b0, m_fire};
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         bank_st_q   <= '{default: B_FREE};
         len_q       <= '{default: '0};
         qent_q      <= '{default: '0};
         qhead_q     <= '0;
         qcnt_q      <= '0;
         wr_act_q    <= 1'b0;
         wr_bank_q   <= '0;
         wcnt_q      <= '0;
         rd_st_q     <= R_IDLE;
         rd_bank_q   <= '0;
         rd_len_q    <= '0;
         rcnt_q      <= '0;
         rv_q        <= 1'b0;
         rl_q        <= 1'b0;
         fifo_dat_q  <= '{default: '0};
         fifo_last_q <= '{default: 1'b0};
         fifo_rp_q   <= 1'b0;
         fifo_occ_q  <= '0;
         rdy_en_q    <= 1'b0;
         trunc_q     <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         bank_st_q   <= bank_st_d;
         len_q       <= len_d;
         qent_q      <= qent_d;
         qhead_q     <= qhead_d;
         qcnt_q      <= qcnt_d;
         wr_act_q    <= wr_act_d;
         wr_bank_q   <= wr_bank_d;
         wcnt_q      <= wcnt_d;
         rd_st_q     <= rd_st_d;
         rd_bank_q   <= rd_bank_d;
         rd_len_q    <= rd_len_d;
         rcnt_q      <= rcnt_d;
         rv_q        <= rv_d;
         rl_q        <= rl_d;
         fifo_dat_q  <= fifo_dat_d;
         fifo_last_q <= fifo_last_d;
         fifo_rp_q   <= fifo_rp_d;
         fifo_occ_q  <= fifo_occ_d;
         rdy_en_q    <= 1'b1;
         trunc_q     <= trunc_d;
         drop_q      <= drop_d;
      end
   end

   // Frame storage: no reset, contents are only read after being written.
   always_ff @(posedge i_clk) begin
      if (we) mem[waddr] <= i_s_data;
      if (rv_d) rdata_q <= mem[raddr];
   end

`ifdef FRAME_STATS_EN
   logic [15:0] f_in_q, f_in_d, f_out_q, f_out_d, f_drop_q, f_drop_d;
   always_comb begin
      f_in_d   = f_in_q + 16'(commit);
      f_out_d  = f_out_q + 16'(last_fire);
      f_drop_d = f_drop_q + 16'(drop_d);
   end
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         f_in_q   <= '0;
         f_out_q  <= '0;
         f_drop_q <= '0;
      end else begin
         f_in_q   <= f_in_d;
         f_out_q  <= f_out_d;
         f_drop_q <= f_drop_d;
      end
   end
   assign o_frames_in      = f_in_q;
   assign o_frames_out     = f_out_q;
   assign o_frames_dropped = f_drop_q;
`endif

endmodule

// File: tb/tb_frame_ring_buf.sv
module tb_frame_ring_buf;
   // Instance 0: blocking mode, MAX_FRAME_LEN=32. Instance 1: drop-oldest, MAX_FRAME_LEN=8.
   logic             clk = 1'b0;
   logic [1:0]       rstn, s_valid, s_ready, s_last, m_valid, m_ready, m_last, swap, trunc, drop;
   logic [1:0][11:0] s_data, m_data;
   logic [1:0][1:0]  queued;
`ifdef FRAME_STATS_EN
   logic [1:0][15:0] f_in, f_out, f_drop;
`endif

   int vecs = 0;
   int errs = 0;
   logic [12:0] exp_q[$];   // {last, data}

   always #5 clk = ~clk;

   frame_ring_buf #(.DATA_WIDTH(12), .MAX_FRAME_LEN(32), .NUM_BANKS(3), .DROP_OLDEST(0)) u_blk (
      .i_clk(clk), .i_rstn(rstn[0]),
      .i_s_valid(s_valid[0]), .o_s_ready(s_ready[0]), .i_s_data(s_data[0]), .i_s_last(s_last[0]),
      .o_m_valid(m_valid[0]), .i_m_ready(m_ready[0]), .o_m_data(m_data[0]), .o_m_last(m_last[0]),
      .i_swap_ok(swap[0]), .o_queued(queued[0]), .o_trunc(trunc[0]), .o_drop(drop[0])
`ifdef FRAME_STATS_EN
      , .o_frames_in(f_in[0]), .o_frames_out(f_out[0]), .o_frames_dropped(f_drop[0])
`endif
   );

   frame_ring_buf #(.DATA_WIDTH(12), .MAX_FRAME_LEN(8), .NUM_BANKS(3), .DROP_OLDEST(1)) u_drop (
      .i_clk(clk), .i_rstn(rstn[1]),
      .i_s_valid(s_valid[1]), .o_s_ready(s_ready[1]), .i_s_data(s_data[1]), .i_s_last(s_last[1]),
      .o_m_valid(m_valid[1]), .i_m_ready(m_ready[1]), .o_m_data(m_data[1]), .o_m_last(m_last[1]),
      .i_swap_ok(swap[1]), .o_queued(queued[1]), .o_trunc(trunc[1]), .o_drop(drop[1])
`ifdef FRAME_STATS_EN
      , .o_frames_in(f_in[1]), .o_frames_out(f_out[1]), .o_frames_dropped(f_drop[1])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one beat at a negedge and return at the negedge after it fired.
   task automatic send_beat(input int d, input logic [11:0] dat, input logic lst);
      int t = 0;
      s_valid[d] = 1'b1;
      s_data[d]  = dat;
      s_last[d]  = lst;
      while (!s_ready[d] && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("s_ready_wait", 32'(s_ready[d]), 32'd1);
      @(negedge clk);
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
   endtask

   task automatic send_frame(input int d, input int base, input int len);
      for (int i = 0; i < len; i++) send_beat(d, 12'(base + i), (i == len - 1));
   endtask

   task automatic expect_frame(input int base, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), 12'(base + i)});
   endtask

   // Drain everything in exp_q, checking order, last flags and hold-on-stall.
   task automatic recv(input int d, input bit rnd);
      int          cyc   = 0;
      int          extra = 0;
      bit          stall = 1'b0;
      logic [11:0] hd    = '0;
      logic        hl    = 1'b0;
      logic [12:0] e;
      while (exp_q.size() > 0 && cyc < 600) begin
         if (stall) begin
            chk("hold_valid", 32'(m_valid[d]), 32'd1);
            chk("hold_data", 32'(m_data[d]), 32'(hd));
            chk("hold_last", 32'(m_last[d]), 32'(hl));
         end
         m_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stall = m_valid[d] && !m_ready[d];
         hd    = m_data[d];
         hl    = m_last[d];
         if (m_valid[d] && m_ready[d]) begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(m_data[d]), 32'(e[11:0]));
            chk("beat_last", 32'(m_last[d]), 32'(e[12]));
         end
         @(negedge clk);
         cyc++;
      end
      chk("drain_done", exp_q.size(), 0);
      exp_q.delete();
      m_ready[d] = 1'b1;
      repeat (4) begin
         if (m_valid[d]) extra++;
         @(negedge clk);
      end
      chk("no_extra_beats", extra, 0);
      m_ready[d] = 1'b0;
   endtask

   initial begin
      rstn = '0; s_valid = '0; s_last = '0; s_data = '0; m_ready = '0; swap = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_s_ready", 32'(s_ready[d]), 0);
         chk("rst_m_valid", 32'(m_valid[d]), 0);
         chk("rst_queued", 32'(queued[d]), 0);
         chk("rst_pulses", 32'({trunc[d], drop[d]}), 0);
      end
      chk("rst_m_data", 32'(m_data[0]), 0);
      rstn = 2'b11;
      @(negedge clk);
      chk("post_rst_ready0", 32'(s_ready[0]), 1);
      chk("post_rst_ready1", 32'(s_ready[1]), 1);

      // Three frames queued in blocking mode, then released in order.
      send_frame(0, 'h100, 5);
      send_frame(0, 'h200, 7);
      send_frame(0, 'h300, 2);
      chk("t1_queued3", 32'(queued[0]), 3);
      chk("t1_blocked", 32'(s_ready[0]), 0);
      expect_frame('h100, 5);
      expect_frame('h200, 7);
      expect_frame('h300, 2);
      swap[0] = 1'b1;
      @(negedge clk);
      chk("t1_lat1", 32'(m_valid[0]), 0);
      @(negedge clk);
      chk("t1_lat2", 32'(m_valid[0]), 1);
      recv(0, 1'b0);
      chk("t1_queued0", 32'(queued[0]), 0);
      chk("t1_ready_again", 32'(s_ready[0]), 1);

      // 20-beat frame drained with random back-pressure.
      send_frame(0, 'h400, 20);
      expect_frame('h400, 20);
      recv(0, 1'b1);

      // Reset while one frame is mid-read, one queued and one mid-write.
      swap[0] = 1'b0;
      send_frame(0, 'h600, 3);
      send_frame(0, 'h610, 3);
      chk("t5_queued2", 32'(queued[0]), 2);
      swap[0] = 1'b1;
      @(negedge clk);
      swap[0] = 1'b0;
      @(negedge clk);
      chk("t5_pre_valid", 32'(m_valid[0]), 1);
      chk("t5_pre_queued", 32'(queued[0]), 1);
      send_beat(0, 'h620, 1'b0);
      send_beat(0, 'h621, 1'b0);
      rstn[0] = 1'b0;
      @(negedge clk);
      chk("t5_rst_valid", 32'(m_valid[0]), 0);
      chk("t5_rst_queued", 32'(queued[0]), 0);
      chk("t5_rst_ready", 32'(s_ready[0]), 0);
      rstn[0] = 1'b1;
      @(negedge clk);
      chk("t5_rel_ready", 32'(s_ready[0]), 1);
      swap[0] = 1'b1;
      send_frame(0, 'h700, 3);
      expect_frame('h700, 3);
      recv(0, 1'b0);

      // Drop-oldest: A, B, C queued, starting D reclaims A.
      send_frame(1, 'h010, 2);
      send_frame(1, 'h020, 3);
      send_frame(1, 'h030, 2);
      chk("t2_queued3", 32'(queued[1]), 3);
      chk("t2_ready", 32'(s_ready[1]), 1);
      send_beat(1, 'h040, 1'b0);
      chk("t2_drop_pulse", 32'(drop[1]), 1);
      chk("t2_queued_after_drop", 32'(queued[1]), 2);
      send_beat(1, 'h041, 1'b1);
      chk("t2_drop_once", 32'(drop[1]), 0);
      chk("t2_queued_d", 32'(queued[1]), 3);
      expect_frame('h020, 3);
      expect_frame('h030, 2);
      expect_frame('h040, 2);
      swap[1] = 1'b1;
      recv(1, 1'b0);
      chk("t2_queued0", 32'(queued[1]), 0);
`ifdef FRAME_STATS_EN
      chk("t6_frames_in", 32'(f_in[1]), 4);
      chk("t6_frames_dropped", 32'(f_drop[1]), 1);
      chk("t6_frames_out", 32'(f_out[1]), 3);
`endif

      // Truncation: 12 beats into an 8-deep bank.
      swap[1] = 1'b0;
      for (int i = 0; i < 11; i++) send_beat(1, 12'('h800 + i), 1'b0);
      chk("t3_no_early_trunc", 32'(trunc[1]), 0);
      send_beat(1, 12'('h80b), 1'b1);
      chk("t3_trunc_pulse", 32'(trunc[1]), 1);
      chk("t3_queued1", 32'(queued[1]), 1);
      @(negedge clk);
      chk("t3_trunc_1cyc", 32'(trunc[1]), 0);
      expect_frame('h800, 8);
      swap[1] = 1'b1;
      recv(1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
